// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: 256-clock PWM whose duty is loaded through a valid/ready target handshake.
// Define PWM_SOFTSTART_EN to ramp duty toward the target; otherwise duty jumps to it at the next wrap.
module pwm_ramp_ctrl #(
  parameter int unsigned STEP         = 1,
  parameter int unsigned STEP_PERIODS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [7:0] duty,
  output logic       period_start,
  output logic       pwm
);

  if (STEP < 1 || STEP > 255 || STEP_PERIODS < 1 || STEP_PERIODS > 255) begin : g_bad_param
    $error("pwm_ramp_ctrl: STEP and STEP_PERIODS must lie in 1..255");
  end

  logic [7:0] cnt;
  logic [7:0] tgt;
  logic       hs;
  logic       wrap;

  assign hs   = target_valid && target_ready;
  assign wrap = en && (cnt == 8'hFF);

  // Comparator and period marker share one register stage so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      pwm          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= en ? cnt + 8'd1 : 8'd0;
      pwm          <= en && (cnt < duty);
      period_start <= en && (cnt == 8'd0);
    end
  end

`ifdef PWM_SOFTSTART_EN
  typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [8:0] STEP9     = 9'(STEP);
  localparam logic [7:0] LAST_STEP = 8'(STEP_PERIODS - 1);

  state_t     state;
  logic [7:0] step_cnt;
  logic [8:0] up_sum;
  logic [8:0] dn_diff;
  logic [7:0] nxt_duty;
  logic [7:0] new_tgt;

  // 9-bit step arithmetic, clamped to tgt so a ramp never overshoots.
  always_comb begin
    up_sum   = {1'b0, duty} + STEP9;
    dn_diff  = {1'b0, duty} - STEP9;
    nxt_duty = tgt;
    if (state == RAMP_UP) begin
      if (up_sum < {1'b0, tgt}) nxt_duty = up_sum[7:0];
    end else if (!dn_diff[8] && (dn_diff[7:0] > tgt)) begin
      nxt_duty = dn_diff[7:0];
    end
  end

  assign new_tgt = hs ? target : tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tgt          <= '0;
      duty         <= '0;
      step_cnt     <= '0;
      target_ready <= 1'b1;
    end else begin
      tgt <= new_tgt;
      if (!en) begin
        state        <= IDLE;
        duty         <= '0;
        target_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            step_cnt <= '0;
            if (new_tgt != 8'd0) begin
              state        <= RAMP_UP;
              target_ready <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (hs && (target != duty)) begin
              state        <= (target > duty) ? RAMP_UP : RAMP_DOWN;
              step_cnt     <= '0;
              target_ready <= 1'b0;
            end
          end
          RAMP_UP, RAMP_DOWN: begin
            if (wrap) begin
              if (step_cnt == LAST_STEP) begin
                step_cnt <= '0;
                duty     <= nxt_duty;
                if (nxt_duty == tgt) begin
                  state        <= HOLD;
                  target_ready <= 1'b1;
                end
              end else begin
                step_cnt <= step_cnt + 8'd1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            duty         <= '0;
            target_ready <= 1'b1;
          end
        endcase
      end
    end
  end
`else
  typedef enum logic {IDLE, HOLD} state_t;

  state_t state;

  assign target_ready = 1'b1;

  // Without soft start the target is applied whole at the next period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt   <= '0;
      duty  <= '0;
    end else begin
      if (hs) tgt <= target;
      if (!en) begin
        state <= IDLE;
        duty  <= '0;
      end else if (state == IDLE) begin
        state <= HOLD;
      end else if (wrap) begin
        duty <= tgt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: three parameterisations driven in lockstep, checked against
// per-cycle reference models plus constant-expectation vectors and corner sequences.
module tb_pwm_ramp_ctrl;

`ifdef PWM_SOFTSTART_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en = 1'b0;
  logic            tv = 1'b0;
  logic [7:0]      target = 8'h00;
  logic [2:0]      rdy, pwm, ps;
  logic [2:0][7:0] duty;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.STEP(1), .STEP_PERIODS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .target(target), .target_valid(tv),
    .target_ready(rdy[0]), .duty(duty[0]), .period_start(ps[0]), .pwm(pwm[0]));
  pwm_ramp_ctrl #(.STEP(5), .STEP_PERIODS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .target(target), .target_valid(tv),
    .target_ready(rdy[1]), .duty(duty[1]), .period_start(ps[1]), .pwm(pwm[1]));
  pwm_ramp_ctrl #(.STEP(255), .STEP_PERIODS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .target(target), .target_valid(tv),
    .target_ready(rdy[2]), .duty(duty[2]), .period_start(ps[2]), .pwm(pwm[2]));

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: the PWM as a free-running 256-clock period plus a duty that walks
  // toward the target; "ramping" is simply "active and duty has not reached the target".
  typedef struct {
    logic [7:0] cnt;
    logic [7:0] duty;
    logic [7:0] tgt;
    bit         active;
    int         wraps;
    bit         pwm;
    bit         ps;
  } mstate_t;

  mstate_t m [3];

  function automatic int step_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 5 : 255;
  endfunction

  function automatic int per_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic mstate_t m_reset();
    mstate_t r;
    r.cnt = 0; r.duty = 0; r.tgt = 0; r.active = 0; r.wraps = 0; r.pwm = 0; r.ps = 0;
    return r;
  endfunction

  function automatic bit m_ready(mstate_t s);
    return SS ? (!s.active || (s.duty == s.tgt)) : 1'b1;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int step, int per, bit e, bit v, logic [7:0] t);
    mstate_t n = s;
    bit ready = m_ready(s);
    bit wrap  = e && (s.cnt == 8'd255);
    int d = s.duty;
    int g = s.tgt;
    if (v && ready) n.tgt = t;
    n.pwm    = e && (s.cnt < s.duty);
    n.ps     = e && (s.cnt == 8'd0);
    n.cnt    = e ? s.cnt + 8'd1 : 8'd0;
    n.active = e;
    if (!e) begin
      n.duty = 0;
    end else if (!SS) begin
      if (wrap) n.duty = s.tgt;
    end else if (s.active && !ready) begin
      if (wrap) begin
        n.wraps = s.wraps + 1;
        if (n.wraps == per) begin
          n.wraps = 0;
          if (g > d) n.duty = 8'((d + step > g) ? g : d + step);
          else       n.duty = 8'((d - step < g) ? g : d - step);
        end
      end
    end else begin
      n.wraps = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) m[i] <= m_reset();
      else        m[i] <= m_step(m[i], step_of(i), per_of(i), en, tv, target);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("model u%0d {duty,pwm,ps,ready}", k),
            {duty[k], pwm[k], ps[k], rdy[k]},
            {m[k].duty, m[k].pwm, m[k].ps, m_ready(m[k])});
    end
  end

  typedef struct {
    bit         en;
    bit         tv;
    logic [7:0] target;
    int         cyc;
    logic [7:0] duty;
    bit         ready;
    bit         pwm;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] bexp [8];
  logic [7:0] mx;
  int         hi, lo0, np, first, gap;

  initial begin
    // Vectors for u0 (STEP=1, STEP_PERIODS=1); each row ends just after its last edge.
    tbl.push_back('{1'b1, 1'b1, 8'h10, 256, SS ? 8'd1 : 8'h10, !SS, 1'b0});
    for (int k = 2; k <= 16; k++)
      tbl.push_back('{1'b1, 1'b0, 8'h00, 256, SS ? 8'(k) : 8'h10, (k == 16) || !SS, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b0});
    for (int k = 1; k <= 7; k++)
      tbl.push_back('{1'b1, 1'b0, 8'h00, 256, SS ? 8'(k) : 8'h10, !SS, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 5, SS ? 8'd7 : 8'h10, !SS, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h40, 256, SS ? 8'd1 : 8'h40, !SS, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 256 * 63, 8'h40, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h3E, 256, SS ? 8'h3F : 8'h3E, !SS, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h99, 100, SS ? 8'h3F : 8'h3E, !SS, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 156, SS ? 8'h3E : 8'h99, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 256, SS ? 8'h3E : 8'h99, 1'b1, 1'b0});
    if (SS) bexp = '{8'd0, 8'd5, 8'd5, 8'd10, 8'd10, 8'd12, 8'd12, 8'd12};
    else    bexp = '{default: 8'd12};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset u%0d {duty,pwm,ps,ready}", k), {duty[k], pwm[k], ps[k], rdy[k]}, 11'h001);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      en = tbl[i].en; tv = tbl[i].tv; target = tbl[i].target;
      @(negedge clk);
      tv = 1'b0;
      repeat (tbl[i].cyc - 1) @(negedge clk);
      chk($sformatf("vec%0d duty", i), duty[0], tbl[i].duty);
      chk($sformatf("vec%0d ready", i), rdy[0], tbl[i].ready);
      chk($sformatf("vec%0d pwm", i), pwm[0], tbl[i].pwm);
    end

    // STEP=5 ramp 0 -> 0x0C on u1: duty at each wrap, and never above 0x0C.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; target = 8'h0C; tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    mx = 8'h00;
    for (int c = 1; c <= 256 * 8; c++) begin
      if (duty[1] > mx) mx = duty[1];
      if (c % 256 == 0) chk($sformatf("u1 wrap%0d duty", c / 256), duty[1], bexp[c / 256 - 1]);
      if (c < 256 * 8) @(negedge clk);
    end
    chk("u1 ramp max duty", mx, 8'h0C);

    // Full duty on u2: 255 high clocks per period, one period_start every 256 clocks.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; target = 8'hFF; tv = 1'b1;
    @(negedge clk);
    tv  = 1'b0;
    lo0 = pwm[0];
    repeat (255) begin
      @(negedge clk);
      lo0 += pwm[0];
    end
    chk("duty0 pwm highs", lo0, 0);
    chk("u2 duty full", duty[2], 8'hFF);
    hi = 0; np = 0; first = -1; gap = -1;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      hi += pwm[2];
      if (ps[2]) begin
        if (first < 0) first = c;
        else           gap = c - first;
        np++;
      end
    end
    chk("u2 pwm highs in 512", hi, 510);
    chk("u2 period_start count", np, 2);
    chk("u2 period_start spacing", gap, 256);

    // Asynchronous reset mid-ramp: outputs must clear before the next clock edge.
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("async reset u%0d", k), {duty[k], pwm[k], ps[k], rdy[k]}, 11'h001);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset u0 idle", {duty[0], pwm[0], ps[0], rdy[0]}, 11'h001);

    // Randomised traffic checked by the per-cycle models.
    en = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      if (en) begin
        if ($urandom_range(0, 2999) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      tv = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) target = 8'($urandom);
      else                           target = m[0].duty + 8'($urandom_range(0, 6)) - 8'd3;
      @(negedge clk);
    end
    tv = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter STEP, default 1, meaning duty increment/decrement per ramp step (legal 1..255).
REQ-002 The block SHALL have parameter STEP_PERIODS, default 1, meaning PWM periods between ramp steps (legal 1..255).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 The block SHALL have port en  input  1  meaning enable PWM generation (1) or force idle (0).
REQ-006 The block SHALL have port target  input  8  meaning requested duty cycle, 0..255 high-clocks per 256-clock period.
REQ-007 The block SHALL have port target_valid  input  1  meaning target is offered this cycle.
REQ-008 The block SHALL have port target_ready  output  1  meaning the controller accepts a new target this cycle.
REQ-009 The block SHALL have port duty  output  8  meaning the duty cycle currently applied to the comparator.
REQ-010 The block SHALL have port period_start  output  1  meaning a one-cycle pulse when the period counter equals 0 while en=1.
REQ-011 The block SHALL have port pwm  output  1  meaning the registered PWM output.

Function
REQ-012 The block SHALL hold an 8-bit period counter that increments each cycle while en=1 and wraps 255->0, giving a 256-clock period.
REQ-013 The pwm output SHALL be registered: pwm(t+1) = (counter(t) < duty(t)), so duty=0 gives constant 0 and duty=255 gives 255 high clocks per period.
REQ-014 The FSM SHALL have states IDLE, HOLD, RAMP_UP and RAMP_DOWN.
REQ-015 A target handshake SHALL complete when target_valid=1 and target_ready=1 on the same clock edge, latching target into an internal tgt register.
REQ-016 target_ready SHALL be 1 in IDLE and HOLD and 0 in RAMP_UP and RAMP_DOWN, so offers during a ramp are ignored and not queued.
REQ-017 In IDLE (en=0), the counter SHALL be held at 0, duty SHALL be 0, pwm SHALL be 0, period_start SHALL be 0, and a handshake SHALL still update tgt.
REQ-018 IDLE SHALL transition on en=1 to RAMP_UP if tgt>0, else to HOLD.
REQ-019 HOLD SHALL transition on a handshake to RAMP_UP if the new target > duty, to RAMP_DOWN if it is < duty, and stay in HOLD if equal.
REQ-020 duty SHALL change only on the clock edge where the counter wraps 255->0, so every period is glitch-free.
REQ-021 In RAMP_UP and RAMP_DOWN, a step counter SHALL count wraps, and duty SHALL move by STEP on every STEP_PERIODS-th wrap.
REQ-022 Step arithmetic SHALL use 9 bits and saturate at tgt with no overshoot: RAMP_UP uses min(duty+STEP, tgt) and RAMP_DOWN uses max(duty-STEP, tgt).
REQ-023 The FSM SHALL enter HOLD on the same edge that duty reaches tgt, and the step counter SHALL clear on every entry to a RAMP state.
REQ-024 en=0 in any state SHALL force IDLE on the next edge, with duty=0 and counter=0; re-enabling SHALL soft-start from duty 0.
REQ-025 A simultaneous en fall and handshake SHALL latch tgt and enter IDLE.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously set state=IDLE, counter=0, step counter=0, tgt=0, duty=0, pwm=0, period_start=0 and target_ready=1.
REQ-027 Reset assertion mid-ramp SHALL abandon the ramp, and the block SHALL leave reset in IDLE on the first edge after rst_n rises.

Configuration
REQ-028 The block SHALL use macro PWM_SOFTSTART_EN: when defined, it behaves as specified above.
REQ-029 When PWM_SOFTSTART_EN is undefined, the RAMP states SHALL be removed, target_ready SHALL be constantly 1, and duty SHALL jump to tgt at the next wrap (or at the first wrap after en rises), ignoring STEP and STEP_PERIODS.

Verification
REQ-030 The bench SHALL check: release rst_n, en=1, default parameters, handshake target=0x10 -> duty steps 1,2,...,16 at successive wraps; HOLD and target_ready=1 after 16 periods (4096 clocks).
REQ-031 The bench SHALL check: STEP=5, ramp from 0 to 0x0C -> duty sequence 5,10,12; no value exceeds 12.
REQ-032 The bench SHALL check: in HOLD at 0x40, handshake target=0x3E -> RAMP_DOWN with duty 0x3F, then 0x3E, then HOLD; a target_valid pulse mid-ramp is ignored and tgt is unchanged.
REQ-033 The bench SHALL check: en dropped mid-ramp at duty=7 -> next edge IDLE, duty=0, pwm=0; en raised again -> ramp restarts from 1.
REQ-034 The bench SHALL check: duty=255 in HOLD -> pwm high exactly 255 of every 256 clocks, and period_start pulses every 256 clocks.
REQ-035 The bench SHALL check: rst_n asserted mid-ramp -> all outputs take reset values asynchronously, before the next clk edge.
